// File: rtl/pipe_ctrl_if.sv
// Control bundle between the 5-stage datapath and pipe_ctrl.
// Carries bus-wait and stage status inputs, and per-stage stall/flush, redirect and CSR outputs.
interface pipe_ctrl_if #(
  parameter int WORD_ADDR_W = 30
);
  // datapath -> controller
  logic                   if_busy;
  logic                   mem_busy;
  logic                   ld_hazard;
  logic                   irq;
  logic                   mem_en;
  logic [WORD_ADDR_W-1:0] mem_pc;
  logic                   mem_br_flag;
  logic [2:0]             mem_exp_code;
  logic [1:0]             mem_ctrl_op;
  logic                   mem_wr_bit;

  // controller -> datapath
  logic                   if_stall;
  logic                   id_stall;
  logic                   ex_stall;
  logic                   mem_stall;
  logic                   if_flush;
  logic                   id_flush;
  logic                   ex_flush;
  logic                   mem_flush;
  logic [WORD_ADDR_W-1:0] new_pc;
  logic                   int_detect;
  logic [WORD_ADDR_W-1:0] epc;
  logic [2:0]             exp_code;
  logic                   int_en;

  modport master (
    output if_busy, mem_busy, ld_hazard, irq, mem_en, mem_pc,
           mem_br_flag, mem_exp_code, mem_ctrl_op, mem_wr_bit,
    input  if_stall, id_stall, ex_stall, mem_stall,
           if_flush, id_flush, ex_flush, mem_flush,
           new_pc, int_detect, epc, exp_code, int_en
  );

  modport slave (
    input  if_busy, mem_busy, ld_hazard, irq, mem_en, mem_pc,
           mem_br_flag, mem_exp_code, mem_ctrl_op, mem_wr_bit,
    output if_stall, id_stall, ex_stall, mem_stall,
           if_flush, id_flush, ex_flush, mem_flush,
           new_pc, int_detect, epc, exp_code, int_en
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: per-stage stall/flush generation, exception/interrupt entry and
// return sequencing, EPC/cause capture and the interrupt-enable register.
module pipe_ctrl #(
  parameter int                     WORD_ADDR_W = 30,
  parameter logic [WORD_ADDR_W-1:0] EXC_VECTOR  = 30'h0000_0010
) (
  input  logic       clk,
  input  logic       reset,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;

  localparam logic [1:0] OP_WRCR = 2'd1;
  localparam logic [1:0] OP_EXRT = 2'd2;

  state_t                 state_q, state_d;
  logic                   int_en_q, int_en_d;
  logic                   pre_int_en_q, pre_int_en_d;
  logic [WORD_ADDR_W-1:0] epc_q, epc_d;
  logic [2:0]             exp_code_q, exp_code_d;
  logic [1:0]             irq_sync_q, irq_sync_d;

  logic                   stall;
  logic                   exc;
  logic                   take_int;
  logic                   exrt;
  logic                   wrcr;
  logic                   int_detect;
  logic [3:0]             stall_vec;
  logic [3:0]             flush_vec;
  logic [WORD_ADDR_W-1:0] new_pc;
  logic [WORD_ADDR_W-1:0] trap_pc;

  // Interrupts are only takeable from RUN; the handler runs with them masked.
  assign int_detect = irq_sync_q[1] & int_en_q & (state_q == RUN);

  always_comb begin
    stall    = bus.if_busy | bus.mem_busy;
    exc      = bus.mem_en & (bus.mem_exp_code != 3'd0);
    take_int = int_detect & bus.mem_en & ~exc;
    exrt     = bus.mem_en & (bus.mem_ctrl_op == OP_EXRT) & ~exc;
    wrcr     = bus.mem_en & (bus.mem_ctrl_op == OP_WRCR) & ~exc;
    // A trap in a branch delay slot must resume at the branch itself.
    trap_pc  = bus.mem_br_flag ? (bus.mem_pc - WORD_ADDR_W'(1)) : bus.mem_pc;
  end

  always_comb begin
    stall_vec    = 4'b0000;
    flush_vec    = 4'b0000;
    new_pc       = EXC_VECTOR;
    state_d      = state_q;
    int_en_d     = int_en_q;
    pre_int_en_d = pre_int_en_q;
    epc_d        = epc_q;
    exp_code_d   = exp_code_q;

    if (stall) begin
      stall_vec = 4'b1111;
    end else if (exc | take_int) begin
      flush_vec  = 4'b1111;
      new_pc     = EXC_VECTOR;
      epc_d      = trap_pc;
      exp_code_d = exc ? bus.mem_exp_code : 3'd1;
      // Nested traps keep the enable that was in force before the first entry.
      if (state_q == RUN) begin
        pre_int_en_d = int_en_q;
      end
      int_en_d   = 1'b0;
      state_d    = HANDLER;
    end else if (exrt) begin
      flush_vec = 4'b1111;
      new_pc    = epc_q;
      int_en_d  = pre_int_en_q;
      state_d   = RUN;
    end else if (wrcr) begin
      int_en_d = bus.mem_wr_bit;
    end else if (bus.ld_hazard) begin
      stall_vec[STG_IF] = 1'b1;
      stall_vec[STG_ID] = 1'b1;
      flush_vec[STG_ID] = 1'b1;
    end
  end

  // The synchronizer runs independently of pipeline stalls.
  always_comb begin
    irq_sync_d = {irq_sync_q[0], bus.irq};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      int_en_q     <= 1'b0;
      pre_int_en_q <= 1'b0;
      epc_q        <= '0;
      exp_code_q   <= 3'd0;
      irq_sync_q   <= 2'b00;
    end else begin
      state_q      <= state_d;
      int_en_q     <= int_en_d;
      pre_int_en_q <= pre_int_en_d;
      epc_q        <= epc_d;
      exp_code_q   <= exp_code_d;
      irq_sync_q   <= irq_sync_d;
    end
  end

  assign bus.if_stall   = stall_vec[STG_IF];
  assign bus.id_stall   = stall_vec[STG_ID];
  assign bus.ex_stall   = stall_vec[STG_EX];
  assign bus.mem_stall  = stall_vec[STG_MEM];
  assign bus.if_flush   = flush_vec[STG_IF];
  assign bus.id_flush   = flush_vec[STG_ID];
  assign bus.ex_flush   = flush_vec[STG_EX];
  assign bus.mem_flush  = flush_vec[STG_MEM];
  assign bus.new_pc     = new_pc;
  assign bus.int_detect = int_detect;
  assign bus.epc        = epc_q;
  assign bus.exp_code   = exp_code_q;
  assign bus.int_en     = int_en_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: the driver queues hand-computed expectations per cycle,
// a negedge monitor pops each one and compares it against the live DUT outputs.
module tb_pipe_ctrl;

  localparam int W = 30;

  typedef struct {
    string       nm;
    logic [72:0] v;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  pipe_ctrl_if #(.WORD_ADDR_W(W)) bus();

  pipe_ctrl #(
    .WORD_ADDR_W(W),
    .EXC_VECTOR (30'h0000_0010)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stall/flush vectors are ordered {if, id, ex, mem}.
  function automatic logic [72:0] pack_out();
    return {bus.if_stall, bus.id_stall, bus.ex_stall, bus.mem_stall,
            bus.if_flush, bus.id_flush, bus.ex_flush, bus.mem_flush,
            bus.new_pc, bus.int_detect, bus.epc, bus.exp_code, bus.int_en};
  endfunction

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [72:0] act;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = pack_out();
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("[%0t] FAIL %s: got st=%b fl=%b npc=%h idet=%b epc=%h ec=%0d ie=%b, need st=%b fl=%b npc=%h idet=%b epc=%h ec=%0d ie=%b",
                 $time, e.nm, act[72:69], act[68:65], act[64:35], act[34], act[33:4], act[3:1], act[0],
                 e.v[72:69], e.v[68:65], e.v[64:35], e.v[34], e.v[33:4], e.v[3:1], e.v[0]);
      end else begin
        $display("[%0t] %s ok", $time, e.nm);
      end
    end
  end

  task automatic chk(input string nm, input logic [3:0] st, input logic [3:0] fl,
                     input logic [W-1:0] npc, input logic idet, input logic [W-1:0] ep,
                     input logic [2:0] ec, input logic ie);
    exp_t e;
    e.nm = nm;
    e.v  = {st, fl, npc, idet, ep, ec, ie};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.if_busy      = 1'b0;
    bus.mem_busy     = 1'b0;
    bus.ld_hazard    = 1'b0;
    bus.mem_en       = 1'b0;
    bus.mem_pc       = '0;
    bus.mem_br_flag  = 1'b0;
    bus.mem_exp_code = 3'd0;
    bus.mem_ctrl_op  = 2'd0;
    bus.mem_wr_bit   = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin : driver
    checks = 0;
    errors = 0;
    clr();
    bus.irq = 1'b0;
    reset   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    chk("reset_idle",       4'h0, 4'h0, 30'h10, 0, 30'h0, 3'd0, 0);
    bus.if_busy = 1;
    chk("if_busy_stall",    4'hF, 4'h0, 30'h10, 0, 30'h0, 3'd0, 0);
    clr(); bus.ld_hazard = 1;
    chk("ld_hazard",        4'hC, 4'h4, 30'h10, 0, 30'h0, 3'd0, 0);
    bus.mem_busy = 1;
    chk("ld_plus_busy",     4'hF, 4'h0, 30'h10, 0, 30'h0, 3'd0, 0);

    clr(); bus.mem_en = 1; bus.mem_pc = 30'h100; bus.mem_exp_code = 3'd3;
    chk("exc_flush",        4'h0, 4'hF, 30'h10, 0, 30'h0, 3'd0, 0);
    clr();
    chk("exc_saved",        4'h0, 4'h0, 30'h10, 0, 30'h100, 3'd3, 0);
    bus.mem_en = 1; bus.mem_pc = 30'h100; bus.mem_br_flag = 1; bus.mem_exp_code = 3'd3;
    chk("exc_br_flush",     4'h0, 4'hF, 30'h10, 0, 30'h100, 3'd3, 0);
    clr();
    chk("exc_br_saved",     4'h0, 4'h0, 30'h10, 0, 30'h0FF, 3'd3, 0);
    bus.mem_en = 1; bus.mem_ctrl_op = 2'd2;
    chk("exrt_from_exc",    4'h0, 4'hF, 30'h0FF, 0, 30'h0FF, 3'd3, 0);
    clr();
    chk("after_exrt",       4'h0, 4'h0, 30'h10, 0, 30'h0FF, 3'd3, 0);

    bus.mem_en = 1; bus.mem_ctrl_op = 2'd1; bus.mem_wr_bit = 1;
    chk("wrcr",             4'h0, 4'h0, 30'h10, 0, 30'h0FF, 3'd3, 0);
    clr(); bus.irq = 1;
    chk("wrcr_done",        4'h0, 4'h0, 30'h10, 0, 30'h0FF, 3'd3, 1);
    chk("irq_sync1",        4'h0, 4'h0, 30'h10, 0, 30'h0FF, 3'd3, 1);
    chk("irq_detect",       4'h0, 4'h0, 30'h10, 1, 30'h0FF, 3'd3, 1);
    bus.mem_en = 1; bus.mem_pc = 30'h200;
    chk("int_take",         4'h0, 4'hF, 30'h10, 1, 30'h0FF, 3'd3, 1);
    clr();
    chk("int_saved",        4'h0, 4'h0, 30'h10, 0, 30'h200, 3'd1, 0);
    bus.mem_en = 1; bus.mem_ctrl_op = 2'd2;
    chk("exrt_from_int",    4'h0, 4'hF, 30'h200, 0, 30'h200, 3'd1, 0);
    clr(); bus.irq = 0;
    chk("exrt_restores",    4'h0, 4'h0, 30'h10, 1, 30'h200, 3'd1, 1);
    chk("irq_drop1",        4'h0, 4'h0, 30'h10, 1, 30'h200, 3'd1, 1);
    chk("irq_drop2",        4'h0, 4'h0, 30'h10, 0, 30'h200, 3'd1, 1);

    bus.mem_en = 1; bus.mem_ctrl_op = 2'd2; bus.mem_exp_code = 3'd5; bus.mem_pc = 30'h300;
    chk("exc_beats_exrt",   4'h0, 4'hF, 30'h10, 0, 30'h200, 3'd1, 1);
    clr();
    chk("exc5_saved",       4'h0, 4'h0, 30'h10, 0, 30'h300, 3'd5, 0);

    bus.mem_en = 1; bus.mem_exp_code = 3'd2; bus.mem_pc = 30'h40; bus.mem_busy = 1;
    chk("exc_stalled",      4'hF, 4'h0, 30'h10, 0, 30'h300, 3'd5, 0);
    chk("exc_still_stalled",4'hF, 4'h0, 30'h10, 0, 30'h300, 3'd5, 0);
    bus.mem_busy = 0;
    chk("exc_released",     4'h0, 4'hF, 30'h10, 0, 30'h300, 3'd5, 0);
    clr();
    chk("exc2_saved",       4'h0, 4'h0, 30'h10, 0, 30'h40, 3'd2, 0);

    bus.mem_en = 1; bus.mem_ctrl_op = 2'd3; bus.mem_wr_bit = 1;
    chk("ctrl_op3_nop",     4'h0, 4'h0, 30'h10, 0, 30'h40, 3'd2, 0);
    clr();
    chk("ctrl_op3_after",   4'h0, 4'h0, 30'h10, 0, 30'h40, 3'd2, 0);
    bus.mem_en = 1; bus.mem_ctrl_op = 2'd1; bus.mem_wr_bit = 1;
    chk("wrcr_in_handler",  4'h0, 4'h0, 30'h10, 0, 30'h40, 3'd2, 0);
    clr(); bus.irq = 1;
    chk("handler_ie1",      4'h0, 4'h0, 30'h10, 0, 30'h40, 3'd2, 1);
    chk("handler_wait",     4'h0, 4'h0, 30'h10, 0, 30'h40, 3'd2, 1);
    chk("handler_irq_mask", 4'h0, 4'h0, 30'h10, 0, 30'h40, 3'd2, 1);

    reset = 0;
    chk("reset_in_handler", 4'h0, 4'h0, 30'h10, 0, 30'h0, 3'd0, 0);
    reset = 1;
    chk("post_reset",       4'h0, 4'h0, 30'h10, 0, 30'h0, 3'd0, 0);
    bus.mem_en = 1; bus.mem_ctrl_op = 2'd2;
    chk("exrt_in_run",      4'h0, 4'hF, 30'h0, 0, 30'h0, 3'd0, 0);
    clr(); bus.irq = 0;
    chk("done_idle",        4'h0, 4'h0, 30'h10, 0, 30'h0, 3'd0, 0);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, need 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
